// File: rtl/mb8_acc_if.sv
// ----------------------------------------------------------------------------
// mb8_acc_if
// Bus bundle between a dot-product sequencer and the mb8_acc accumulator.
//   start     : begin a new accumulation (clears sum, count, sat flag)
//   in_valid  : product1 carries a valid product this cycle
//   product1  : signed 2*WIDTH-bit product from the Booth multiplier
//   acc_out   : registered signed running / final sum
//   out_valid : one-cycle pulse, acc_out holds the final sum
//   busy      : high while an accumulation is in progress
//   sat       : sticky, some addition in this accumulation clamped
// Modports: master drives the request side, slave is the accumulator.
// ----------------------------------------------------------------------------
interface mb8_acc_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24
);
  logic                   start;
  logic                   in_valid;
  logic [2*WIDTH-1:0]     product1;
  logic [ACC_WIDTH-1:0]   acc_out;
  logic                   out_valid;
  logic                   busy;
  logic                   sat;

  modport master (
    output start,
    output in_valid,
    output product1,
    input  acc_out,
    input  out_valid,
    input  busy,
    input  sat
  );

  modport slave (
    input  start,
    input  in_valid,
    input  product1,
    output acc_out,
    output out_valid,
    output busy,
    output sat
  );
endinterface

// File: rtl/mb8_acc.sv
// ----------------------------------------------------------------------------
// mb8_acc
// Saturating dot-product accumulator behind an 8x8 Booth multiplier. After a
// start it sums LEN signed products (one per in_valid cycle, arbitrary gaps
// allowed) into a signed ACC_WIDTH-bit register, clamping at the signed range
// limits, then pulses out_valid for one cycle with the final sum.
// Ports:
//   CLK : rising-edge clock
//   RST : asynchronous active-low reset
//   bus : mb8_acc_if slave modport (start, in_valid, product1 in;
//         acc_out, out_valid, busy, sat out -- all outputs registered)
// ----------------------------------------------------------------------------
module mb8_acc #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int LEN       = 16
) (
  input  logic    CLK,
  input  logic    RST,
  mb8_acc_if.slave bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturating add of a sign-extended product to the accumulator.
  // Returns {clamped, result}. Because ACC_WIDTH > 2*WIDTH the exact sum
  // always fits in ACC_WIDTH+1 bits, so overflow shows as the top two bits
  // of that widened sum disagreeing; the top bit gives the direction.
  function automatic logic [ACC_WIDTH:0] sat_add(
    input logic [ACC_WIDTH-1:0] a,
    input logic [PW-1:0]        p
  );
    logic [ACC_WIDTH:0] ext_a;
    logic [ACC_WIDTH:0] ext_p;
    logic [ACC_WIDTH:0] sum;
    logic [ACC_WIDTH:0] res;
    ext_a = {a[ACC_WIDTH-1], a};
    ext_p = {{(ACC_WIDTH + 1 - PW){p[PW-1]}}, p};
    sum   = ext_a + ext_p;
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      if (sum[ACC_WIDTH] == 1'b0) begin
        res = {1'b1, 1'b0, {(ACC_WIDTH - 1){1'b1}}};
      end else begin
        res = {1'b1, 1'b1, {(ACC_WIDTH - 1){1'b0}}};
      end
    end else begin
      res = {1'b0, sum[ACC_WIDTH-1:0]};
    end
    return res;
  endfunction

  state_t               state_r;
  state_t               state_nxt_s;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [ACC_WIDTH-1:0] acc_nxt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic                 sat_r;
  logic                 sat_nxt_s;
  logic                 busy_r;
  logic                 busy_nxt_s;
  logic                 out_valid_r;
  logic                 out_valid_nxt_s;
  logic [ACC_WIDTH:0]   add_res_s;

  // Candidate accumulator value for the current product.
  always_comb begin
    add_res_s = sat_add(acc_r, bus.product1);
  end

  // Next-state and next-output logic; a start always wins over in_valid.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    sat_nxt_s   = sat_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = ACC;
          acc_nxt_s   = {ACC_WIDTH{1'b0}};
          cnt_nxt_s   = {CNT_W{1'b0}};
          sat_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACC: begin
        if (bus.start) begin
          // Abort: restart from zero and drop this cycle's product.
          state_nxt_s = ACC;
          acc_nxt_s   = {ACC_WIDTH{1'b0}};
          cnt_nxt_s   = {CNT_W{1'b0}};
          sat_nxt_s   = 1'b0;
        end else if (bus.in_valid) begin
          acc_nxt_s = add_res_s[ACC_WIDTH-1:0];
          cnt_nxt_s = cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
          sat_nxt_s = sat_r | add_res_s[ACC_WIDTH];
          if (cnt_r == CNT_W'(LEN - 1)) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = ACC;
          end
        end else begin
          state_nxt_s = ACC;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nxt_s = ACC;
          acc_nxt_s   = {ACC_WIDTH{1'b0}};
          cnt_nxt_s   = {CNT_W{1'b0}};
          sat_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        acc_nxt_s   = {ACC_WIDTH{1'b0}};
        cnt_nxt_s   = {CNT_W{1'b0}};
        sat_nxt_s   = 1'b0;
      end
    endcase
    // Status outputs are registered copies decoded from the next state.
    busy_nxt_s      = (state_nxt_s == ACC);
    out_valid_nxt_s = (state_nxt_s == DONE);
  end

  // State, datapath and registered outputs; RST clears everything at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= IDLE;
      acc_r       <= {ACC_WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      sat_r       <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      cnt_r       <= cnt_nxt_s;
      sat_r       <= sat_nxt_s;
      busy_r      <= busy_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  assign bus.acc_out   = acc_r;
  assign bus.sat       = sat_r;
  assign bus.busy      = busy_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_mb8_acc.sv
// ----------------------------------------------------------------------------
// tb_mb8_acc
// Directed plus randomized bench for mb8_acc (WIDTH=8, ACC_WIDTH=17, LEN=4).
// A reference model keeps the list-of-products view of an accumulation:
// integer running sum clamped to the signed range, number of products taken,
// and whether a dot product is open. Every output is checked after each edge.
// ----------------------------------------------------------------------------
module tb_mb8_acc;

  localparam int W  = 8;
  localparam int AW = 17;
  localparam int L  = 4;

  logic CLK;
  logic RST;

  mb8_acc_if #(.WIDTH(W), .ACC_WIDTH(AW)) bus ();

  mb8_acc #(.WIDTH(W), .ACC_WIDTH(AW), .LEN(L)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  longint m_sum;
  int     m_n;
  bit     m_open;
  bit     m_sat;
  bit     m_ov;

  localparam longint MAXV = (64'sd1 <<< (AW - 1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (AW - 1));

  task automatic model_reset();
    m_sum  = 0;
    m_n    = 0;
    m_open = 1'b0;
    m_sat  = 1'b0;
    m_ov   = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit iv, input logic signed [15:0] p);
    longint s;
    m_ov = 1'b0;
    if (st) begin
      m_open = 1'b1;
      m_sum  = 0;
      m_n    = 0;
      m_sat  = 1'b0;
    end else if (m_open && iv) begin
      s = m_sum + longint'(p);
      if (s > MAXV) begin
        s = MAXV;
        m_sat = 1'b1;
      end
      if (s < MINV) begin
        s = MINV;
        m_sat = 1'b1;
      end
      m_sum = s;
      m_n   = m_n + 1;
      if (m_n == L) begin
        m_open = 1'b0;
        m_ov   = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string where);
    logic signed [AW-1:0] acc_v;
    acc_v = bus.acc_out;
    check({where, ".acc_out"},   acc_v,                 m_sum);
    check({where, ".out_valid"}, {63'd0, bus.out_valid}, {63'd0, m_ov});
    check({where, ".busy"},      {63'd0, bus.busy},      {63'd0, m_open});
    check({where, ".sat"},       {63'd0, bus.sat},       {63'd0, m_sat});
  endtask

  task automatic cycle(input string where, input bit st, input bit iv,
                       input logic signed [15:0] p);
    bus.start    = st;
    bus.in_valid = iv;
    bus.product1 = p;
    @(posedge CLK);
    model_edge(st, iv, p);
    #1;
    check_all(where);
  endtask

  initial begin
    logic signed [15:0] rp;
    bit                 rs;
    bit                 rv;

    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.product1 = 16'sd0;
    RST          = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 check_all("reset_rel");

    // First edge after reset is a normal idle cycle: product ignored
    cycle("idle_ign", 1'b0, 1'b1, 16'sd55);

    // Basic: 3, -5, 7, 100 -> 105
    cycle("b_start", 1'b1, 1'b0, 16'sd0);
    cycle("b_p0",    1'b0, 1'b1, 16'sd3);
    cycle("b_p1",    1'b0, 1'b1, -16'sd5);
    cycle("b_p2",    1'b0, 1'b1, 16'sd7);
    cycle("b_p3",    1'b0, 1'b1, 16'sd100);
    check("b_final", 64'(bus.acc_out), 64'sd105);
    cycle("b_hold",  1'b0, 1'b1, 16'sd9);

    // Gaps of two idle cycles between products
    cycle("g_start", 1'b1, 1'b0, 16'sd0);
    cycle("g_p0", 1'b0, 1'b1, 16'sd3);
    cycle("g_i0", 1'b0, 1'b0, 16'sd0);
    cycle("g_i1", 1'b0, 1'b0, 16'sd0);
    cycle("g_p1", 1'b0, 1'b1, -16'sd5);
    cycle("g_i2", 1'b0, 1'b0, 16'sd0);
    cycle("g_i3", 1'b0, 1'b0, 16'sd0);
    cycle("g_p2", 1'b0, 1'b1, 16'sd7);
    cycle("g_i4", 1'b0, 1'b0, 16'sd0);
    cycle("g_i5", 1'b0, 1'b0, 16'sd0);
    cycle("g_p3", 1'b0, 1'b1, 16'sd100);
    cycle("g_after", 1'b0, 1'b0, 16'sd0);

    // Positive saturation, then negative saturation
    cycle("sp_start", 1'b1, 1'b0, 16'sd0);
    for (int i = 0; i < L; i++) cycle("sp_p", 1'b0, 1'b1, 16'sd32767);
    check("sp_final", 64'(bus.acc_out), 64'sd65535);
    cycle("sn_start", 1'b1, 1'b0, 16'sd0);
    for (int i = 0; i < L; i++) cycle("sn_p", 1'b0, 1'b1, -16'sd32768);
    check("sn_final", 64'($signed(bus.acc_out)), -64'sd65536);

    // Abort with start coincident with a product
    cycle("a_start", 1'b1, 1'b0, 16'sd0);
    cycle("a_p10",   1'b0, 1'b1, 16'sd10);
    cycle("a_p20",   1'b0, 1'b1, 16'sd20);
    cycle("a_abort", 1'b1, 1'b1, 16'sd50);
    cycle("a_p1",    1'b0, 1'b1, 16'sd1);
    cycle("a_p2",    1'b0, 1'b1, 16'sd2);
    cycle("a_p3",    1'b0, 1'b1, 16'sd3);
    cycle("a_p4",    1'b0, 1'b1, 16'sd4);
    check("a_final", 64'(bus.acc_out), 64'sd10);

    // Back-to-back: saturate, then start in the DONE cycle
    cycle("bb_start", 1'b1, 1'b0, 16'sd0);
    for (int i = 0; i < L; i++) cycle("bb_v1", 1'b0, 1'b1, 16'sd30000);
    cycle("bb_restart", 1'b1, 1'b1, 16'sd999);
    cycle("bb_v2a", 1'b0, 1'b1, -16'sd1);
    cycle("bb_v2b", 1'b0, 1'b1, -16'sd2);
    cycle("bb_v2c", 1'b0, 1'b1, 16'sd300);
    cycle("bb_v2d", 1'b0, 1'b1, -16'sd7);
    cycle("bb_idle", 1'b0, 1'b0, 16'sd0);

    // Asynchronous reset mid-accumulation, between edges
    cycle("r_start", 1'b1, 1'b0, 16'sd0);
    cycle("r_p0",    1'b0, 1'b1, 16'sd1234);
    cycle("r_p1",    1'b0, 1'b1, 16'sd32767);
    cycle("r_p2",    1'b0, 1'b1, 16'sd32767);
    bus.in_valid = 1'b1;
    bus.product1 = 16'sd5;
    #1 RST = 1'b0;
    model_reset();
    #1 check_all("r_async");
    @(posedge CLK);
    #1 check_all("r_held");
    #1 RST = 1'b1;
    cycle("r_ign0", 1'b0, 1'b1, 16'sd77);
    cycle("r_ign1", 1'b0, 1'b1, 16'sd88);
    cycle("r_fresh", 1'b1, 1'b0, 16'sd0);
    for (int i = 0; i < L; i++) cycle("r_sum", 1'b0, 1'b1, 16'(i * 11 - 7));

    // Randomized traffic: sparse starts, bursty valids, extreme products
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 11) == 0);
      rv = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       rp = 16'sd32767;
        1:       rp = -16'sd32768;
        default: rp = 16'($urandom);
      endcase
      cycle("rand", rs, rv, rp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mb8_acc.md
MB8_ACC -- requirements
Module: mb8_acc

Interface
REQ-001 Parameter WIDTH, default 8, operand width of the upstream Booth multiplier; the product input is 2*WIDTH bits.
REQ-002 Parameter ACC_WIDTH, default 24, accumulator width; legal range 2*WIDTH+1 .. 48.
REQ-003 Parameter LEN, default 16, number of products per dot product; legal range 2 .. 256.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  begin a new accumulation; clears the sum, count and saturation flag.
REQ-007 in_valid  input  1  product1 carries a valid product this cycle.
REQ-008 product1  input  2*WIDTH  signed two's-complement product from the upstream multiplier.
REQ-009 acc_out  output  ACC_WIDTH  registered signed running or final sum.
REQ-010 out_valid  output  1  registered one-cycle pulse; acc_out holds the final LEN-product sum.
REQ-011 busy  output  1  registered; high while in ACC.
REQ-012 sat  output  1  registered sticky flag; set when any addition in the current accumulation clamped.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-014 IDLE: busy=0 and out_valid=0; in_valid is ignored; start=1 SHALL move to ACC and, at the same edge, set acc_out=0, count=0 and sat=0.
REQ-015 ACC: busy=1; on each edge with in_valid=1, acc_out SHALL become sat_add(acc_out, sign-extended product1) and count SHALL increment by 1.
REQ-016 ACC: on an edge with in_valid=0, acc_out, count and sat SHALL hold; the block imposes no limit on idle gaps.
REQ-017 ACC: the edge that accepts a product while count=LEN-1 SHALL move to DONE, with acc_out holding the final sum.
REQ-018 Latency: out_valid SHALL go high in the cycle immediately after the final product is presented (one edge).
REQ-019 DONE: out_valid=1 and busy=0 for exactly one cycle; the next state is IDLE, or ACC if start=1.
REQ-020 A start in DONE SHALL clear acc_out, count and sat exactly as a start in IDLE does.
REQ-021 A start in ACC SHALL abort the current accumulation: clear acc_out, count and sat, remain in ACC and ignore that cycle's in_valid.
REQ-022 A start in the same cycle as in_valid SHALL always take priority; that product is discarded.
REQ-023 Saturating add: if the exact sum exceeds 2^(ACC_WIDTH-1)-1 it SHALL clamp to that value; if it is below -2^(ACC_WIDTH-1) it SHALL clamp to that value.
REQ-024 Any clamp SHALL set sat=1 at the same edge; later in-range additions proceed from the clamped value.
REQ-025 Outside ACC, acc_out and sat SHALL hold their last values until the next start.
REQ-026 count SHALL be ceil(log2(LEN+1)) bits wide and SHALL never wrap within an accumulation.

Reset
REQ-027 RST=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, acc_out=0, count=0, out_valid=0, busy=0 and sat=0.
REQ-028 Reset mid-accumulation SHALL discard the partial sum; a fresh start is required after RST returns high.
REQ-029 The first edge after RST deasserts SHALL be handled as a normal IDLE cycle.

Verification
REQ-030 Basic (LEN=4): start, then products 3, -5, 7, 100 on consecutive cycles -> one cycle after 100, out_valid=1, acc_out=105, sat=0, busy=0.
REQ-031 Gaps (LEN=4): same products with in_valid low for 2 cycles between each -> acc_out=105 with out_valid asserted exactly once, one cycle after the last product.
REQ-032 Saturation (ACC_WIDTH=17, LEN=4): 32767 four times -> acc_out=65535 and sat=1; then start followed by -32768 four times -> acc_out=-65536 and sat=1.
REQ-033 Abort: start, products 10 and 20, then start together with in_valid (product 50), then products 1, 2, 3, 4 -> acc_out=10 and out_valid asserted once.
REQ-034 Back-to-back: start asserted in the DONE cycle -> next cycle busy=1, acc_out=0, sat=0, and the second vector sums correctly.
REQ-035 Reset: RST driven low mid-ACC between clock edges -> all outputs are 0 before the next edge, and in_valid is ignored until a new start.
